fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the main decoder. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake, presents it with its opcode field to the decoder and datapath, and computes the next PC from the decoder's `branch`/`jump` controls and the ALU `zero` flag once the datapath accepts the instruction. Non-pipelined: exactly one instruction is outstanding at any time.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded at reset. Must be word aligned.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch byte address; equals current PC.
- `imem_ack`  in  1: memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word.
- `instr`  out  32: held instruction register.
- `op`  out  6: `instr[31:26]`, drives the decoder's opcode input.
- `instr_valid`  out  1: `instr` is valid and awaiting accept.
- `instr_accept`  in  1: datapath retires the held instruction this cycle.
- `branch`, `jump`  in  1 each: decoder controls, sampled at accept.
- `zero`  in  1: ALU zero flag, sampled at accept.
- `pcplus4`  out  32: PC + 4, for the datapath.
- `illegal_op`  out  1: sticky unsupported-opcode flag (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- Reset (async, `reset_n`=0): state IDLE, PC=`RESET_PC`, `instr`=0, `illegal_op`=0. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `op`=0, `instr_valid`=0, `pcplus4`=`RESET_PC`+4.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- FETCH: `imem_req`=1, `imem_addr`=PC, held stable until ack. On `imem_ack`=1: `instr` <= `imem_rdata`, go to HOLD.
- HOLD: `instr_valid`=1, `imem_req`=0. On `instr_accept`=1: update PC, go to FETCH.
- Next PC at accept, priority order:
  - `jump`=1: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - `branch`=1 and `zero`=1: `pcplus4 + (sext(instr[15:0]) << 2)`, 32-bit, modulo 2^32.
  - otherwise: `pcplus4`.
- `jump` and `branch` both high: jump wins.
- `pcplus4` wraps modulo 2^32 (`32'hFFFF_FFFC` -> `32'h0000_0000`).
- PC[1:0] is always `2'b00`; all next-PC sources are word aligned by construction.
- `imem_ack` outside FETCH is ignored. `instr_accept` outside HOLD is ignored.
- `branch`/`jump`/`zero` are ignored except in the accept cycle.
- Reset asserted mid-fetch or mid-hold aborts immediately; the pending instruction is discarded.

## Timing
- `imem_req`, `imem_addr`, `instr_valid`, `op`, `pcplus4` are decoded from registered state/PC; no combinational path from any input to any output.
- Ack in the first FETCH cycle: `instr_valid`=1 on the next cycle (1-cycle fetch latency minimum).
- Accept in the first HOLD cycle: `imem_req`=1 with new `imem_addr` on the next cycle.
- Minimum throughput: one instruction per 2 cycles. First `imem_req` at cycle 1 after reset release.
- Memory wait states extend FETCH indefinitely. Accept delays extend HOLD indefinitely; `instr` is stable throughout HOLD.

## Configuration
- `FETCH_ILLEGAL_TRAP_EN` defined: on ack in FETCH, if `imem_rdata[31:26]` is not one of `000000`, `100011`, `101011`, `000100`, `001000`, `000010`, the word is still captured into `instr`. `illegal_op` <= 1 and the state goes to HALT instead of HOLD. HALT: `imem_req`=0, `instr_valid`=0, PC frozen; only reset exits.
- Not defined: `illegal_op` is tied 0, HALT is unreachable, and every opcode proceeds to HOLD.

## Test plan
- Reset release with `RESET_PC`=`32'h0000_0040`, `imem_ack` tied 1 -> `imem_req`=1 with `imem_addr`=`32'h40` at cycle 1; `instr_valid`=1 at cycle 2; `pcplus4`=`32'h44`.
- Sequential: accept with `branch`=`jump`=0, memory with 3 wait states -> next `imem_addr`=`32'h44`; `imem_addr` stable across all 4 FETCH cycles; `instr_valid` rises exactly 1 cycle after ack.
- Branch taken: PC=`32'h100`, instr=`32'h1000_FFFE` (beq, imm=-2), `branch`=`zero`=1 at accept -> next PC `32'h0FC`. Same with `zero`=0 -> next PC `32'h104`.
- Jump with a simultaneous branch: PC=`32'h8000_0010`, instr=`32'h0800_0004`, `jump`=`branch`=`zero`=1 -> next PC `32'h8000_0010`. Wrap: PC=`32'hFFFF_FFFC` with a sequential accept -> next PC `32'h0`.
- Robustness: `imem_ack` pulsed during HOLD and `instr_accept` pulsed during FETCH -> no state or PC change. `reset_n` low mid-FETCH -> all outputs return to their reset values asynchronously.
- With `FETCH_ILLEGAL_TRAP_EN`: fetch `32'hFC00_0000` (op `111111`) -> `illegal_op`=1 next cycle, `instr_valid` stays 0, no further `imem_req` until reset. Without the macro: same word -> `instr_valid`=1, `illegal_op`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: non-pipelined instruction fetch stage feeding the main decoder.
// Holds the PC, fetches one instruction word at a time over a req/ack
// handshake, and computes the next PC from jump/branch/zero once the
// datapath accepts the held instruction.
// Optional build macro: FETCH_ILLEGAL_TRAP_EN enables the unsupported-opcode
// trap. When it is defined, the unit halts and raises a sticky illegal_op.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset; moves to FETCH on the first clock edge
// FETCH | imem_req high at PC; waits for imem_ack to capture the word
// HOLD  | instr_valid high; waits for instr_accept, then updates the PC
// HALT  | trapped on an unsupported opcode; only reset leaves this state

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pcplus4,
  output logic        illegal_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_q, instr_next;
  logic        op_bad;
  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Classify the incoming word's opcode against the supported set.
  always_comb begin
    op_bad = 1'b1;
    case (imem_rdata[31:26])
      6'b000000, 6'b100011, 6'b101011,
      6'b000100, 6'b001000, 6'b000010: op_bad = 1'b0;
      default:                         op_bad = 1'b1;
    endcase
  end

  // Sticky trap flag, set when an unsupported word is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (state == FETCH && imem_ack && op_bad) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign op_bad     = 1'b0;
  assign illegal_op = 1'b0;
`endif

  // All outputs decode from registered state and PC only.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign pcplus4     = pc + 32'd4;

  // Candidate next-PC sources; every source is word aligned by construction.
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_tgt = pcplus4 + branch_off;
  assign jump_tgt   = {pcplus4[31:28], instr_q[25:0], 2'b00};

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      instr_q <= instr_next;
    end
  end

  // Next-state logic; controls are only looked at in the accept cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr_q;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = op_bad ? HALT : HOLD;
        end
      end
      HOLD: begin
        if (instr_accept) begin
          state_next = FETCH;
          if (jump) begin
            pc_next = jump_tgt;
          end else if (branch && zero) begin
            pc_next = branch_tgt;
          end else begin
            pc_next = pcplus4;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetch/branch/jump/wrap cases followed by
// randomized transactions, with wait states, hold delays and ignored
// ack/accept pulses. Expected PCs come from a transaction-level model.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pcplus4;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_valid(instr_valid),
    .instr_accept(instr_accept),
    .branch(branch), .jump(jump), .zero(zero),
    .pcplus4(pcplus4), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next PC straight from the architectural rules.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input bit br, input bit jp, input bit z);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    if (br && z) begin
      off = int'($signed(w[15:0])) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  // One full instruction: caller is at a negedge with the DUT in FETCH.
  task automatic fetch_one(input logic [31:0] w, input int waits, input int holds,
                           input bit br, input bit jp, input bit z);
    for (int i = 0; i <= waits; i++) begin
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, model_pc);
      chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack     = (i == waits);
      imem_rdata   = (i == waits) ? w : $urandom;
      instr_accept = 1'($urandom);
      branch       = 1'($urandom);
      jump         = 1'($urandom);
      zero         = 1'($urandom);
      @(negedge clk);
    end
    for (int j = 0; j <= holds; j++) begin
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", instr, w);
      chk("hold_op", {26'd0, op}, {26'd0, w[31:26]});
      chk("hold_pcplus4", pcplus4, model_pc + 32'd4);
      chk("hold_addr", imem_addr, model_pc);
      chk("hold_illegal", {31'd0, illegal_op}, 32'd0);
      imem_ack     = 1'($urandom);
      imem_rdata   = $urandom;
      instr_accept = (j == holds);
      branch       = (j == holds) ? br : 1'($urandom);
      jump         = (j == holds) ? jp : 1'($urandom);
      zero         = (j == holds) ? z  : 1'($urandom);
      @(negedge clk);
    end
    model_pc     = next_pc(model_pc, w, br, jp, z);
    imem_ack     = 1'b0;
    instr_accept = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_op"}, {26'd0, op}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_pcplus4"}, pcplus4, RPC + 32'd4);
    chk({tag, "_illegal"}, {31'd0, illegal_op}, 32'd0);
  endtask

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b001000, 6'b000010};

  initial begin
    logic [31:0] w;
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_accept = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    model_pc = RPC;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: sequential, wait states, jump, branch taken/not, wrap, jump over branch.
    fetch_one(32'h0000_0020, 0, 0, 0, 0, 0);
    chk("seq_addr", model_pc, 32'h44);
    fetch_one(32'h0800_0040, 3, 2, 0, 1, 0);
    chk("jump_pc", model_pc, 32'h100);
    fetch_one(32'h1000_FFFE, 1, 0, 1, 0, 1);
    chk("beq_taken", model_pc, 32'h0FC);
    fetch_one(32'h1000_FFFE, 0, 1, 1, 0, 0);
    chk("beq_not_taken", model_pc, 32'h100);
    fetch_one(32'h1000_FFBD, 0, 0, 1, 0, 1);
    chk("beq_back", model_pc, 32'hFFFF_FFF8);
    fetch_one(32'h0000_0000, 0, 0, 0, 0, 0);
    fetch_one(32'h0000_0000, 2, 0, 0, 0, 1);
    chk("wrap_pc", model_pc, 32'h0);
    fetch_one(32'h0800_0004, 0, 0, 1, 1, 1);
    chk("jump_wins", model_pc, 32'h10);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
`ifdef FETCH_ILLEGAL_TRAP_EN
      w[31:26] = legal_ops[$urandom_range(0, 5)];
`endif
      fetch_one(w, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a fetch.
    chk("midfetch_req", {31'd0, imem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_pc = RPC;
    @(negedge clk);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, RPC);

    // Unsupported opcode.
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    @(negedge clk);
    imem_ack = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("trap_illegal", {31'd0, illegal_op}, 32'd1);
    chk("trap_instr", instr, 32'hFC00_0000);
    for (int k = 0; k < 5; k++) begin
      chk("trap_valid", {31'd0, instr_valid}, 32'd0);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      chk("trap_addr", imem_addr, RPC);
      instr_accept = 1'b1; imem_ack = 1'b1;
      @(negedge clk);
    end
    instr_accept = 1'b0; imem_ack = 1'b0;
`else
    chk("noTrap_valid", {31'd0, instr_valid}, 32'd1);
    chk("noTrap_illegal", {31'd0, illegal_op}, 32'd0);
    chk("noTrap_op", {26'd0, op}, 32'h3F);
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    chk("noTrap_next_addr", imem_addr, RPC + 32'd4);
    chk("noTrap_next_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
